// File: rtl/mem_regs_pkg.sv
// Shared types for the mem_regs register bank: error-counter width and a saturating add.
package mem_regs_pkg;

    localparam int ERR_CNT_W = 16;

    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    // Adds 0..2 errors and clamps at all-ones instead of wrapping.
    function automatic err_cnt_t err_sat_add(input err_cnt_t cnt, input logic [1:0] inc);
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mem_regs_addr_dec.sv
// Word-address decoder: one-hot register select, in-range flag and read-only violation flag.
module mem_regs_addr_dec #(
    parameter int                    REGISTER_N     = 16,
    parameter int                    REG_ADDR_WIDTH = 9,
    parameter logic [REGISTER_N-1:0] RO_MASK        = '0
)(
    input  logic [REG_ADDR_WIDTH-1:0] i_addr,
    output logic [REGISTER_N-1:0]     o_sel,
    output logic                      o_in_range,
    output logic                      o_ro_viol
);

    // Out-of-range addresses match no entry, so o_sel is all-zero for them.
    for (genvar g = 0; g < REGISTER_N; g++) begin : g_sel
        assign o_sel[g] = (32'(i_addr) == g);
    end

    assign o_in_range = (32'(i_addr) < REGISTER_N);
    assign o_ro_viol  = |(o_sel & RO_MASK);

endmodule

// File: rtl/mem_regs_pipe.sv
// Register-bank front end: single-cycle write/read requests, 1-cycle write ack, 1-cycle read
// latency (2 with MEM_REGS_PIPE_RD_PIPE_EN), saturating access-error counter.
module mem_regs_pipe
    import mem_regs_pkg::*;
#(
    parameter int                    REGISTER_N     = 16,
    parameter int                    REG_DATA_WIDTH = 32,
    parameter int                    REG_ADDR_WIDTH = 9,
    parameter logic [REGISTER_N-1:0] RO_MASK        = '0
)(
    input  logic                                           axi_clk,
    input  logic                                           axi_resetn,
    input  logic                                           mem_wrReq,
    input  logic [REG_ADDR_WIDTH-1:0]                      mem_wrAddr,
    input  logic [REG_DATA_WIDTH-1:0]                      mem_wrdin,
    input  logic [REG_DATA_WIDTH/8-1:0]                    mem_wrByteStrobe,
    output logic                                           mem_wrAck,
    output logic                                           mem_wrErr,
    input  logic                                           mem_rdReq,
    input  logic [REG_ADDR_WIDTH-1:0]                      mem_rdAddr,
    output logic [REG_DATA_WIDTH-1:0]                      mem_rddout,
    output logic                                           mem_rdValid,
    output logic                                           mem_rdErr,
    output logic [REG_DATA_WIDTH-1:0]                      reg_wrdout,
    output logic [REGISTER_N-1:0][REG_DATA_WIDTH/8-1:0]    reg_wrByteStrobe,
    output logic [REGISTER_N-1:0]                          reg_rdStrobe,
    input  logic [REGISTER_N-1:0][REG_DATA_WIDTH-1:0]      reg_rddin,
    output err_cnt_t                                       err_cnt,
    input  logic                                           err_clr
);

    logic [REGISTER_N-1:0]     w_wr_sel, w_rd_sel;
    logic                      w_wr_inr, w_wr_ro, w_rd_inr, w_rd_ro;
    logic                      w_wr_err, w_rd_err;
    logic [1:0]                w_err_inc;
    logic [REG_DATA_WIDTH-1:0] w_rd_mux;

    logic                                        r_wr_ack, r_wr_err;
    logic [REG_DATA_WIDTH-1:0]                   r_wr_data;
    logic [REGISTER_N-1:0][REG_DATA_WIDTH/8-1:0] r_wr_strb;
    logic                                        r_rd_vld, r_rd_err;
    logic [REG_DATA_WIDTH-1:0]                   r_rd_data;
    err_cnt_t                                    r_err_cnt;

    mem_regs_addr_dec #(
        .REGISTER_N(REGISTER_N), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .RO_MASK(RO_MASK)
    ) u_wr_dec (
        .i_addr(mem_wrAddr), .o_sel(w_wr_sel), .o_in_range(w_wr_inr), .o_ro_viol(w_wr_ro)
    );

    // Reads of RO registers are legal, so the read decoder sees an empty RO mask.
    mem_regs_addr_dec #(
        .REGISTER_N(REGISTER_N), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .RO_MASK('0)
    ) u_rd_dec (
        .i_addr(mem_rdAddr), .o_sel(w_rd_sel), .o_in_range(w_rd_inr), .o_ro_viol(w_rd_ro)
    );

    assign w_wr_err  = !w_wr_inr || w_wr_ro;
    assign w_rd_err  = !w_rd_inr || w_rd_ro;
    assign w_err_inc = {1'b0, mem_wrReq & w_wr_err} + {1'b0, mem_rdReq & w_rd_err};

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < REGISTER_N; i++)
            if (w_rd_sel[i]) w_rd_mux = w_rd_mux | reg_rddin[i];
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_wr_ack  <= 1'b0;
            r_wr_err  <= 1'b0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
        end else begin
            r_wr_ack <= mem_wrReq;
            r_wr_err <= mem_wrReq & w_wr_err;
            if (mem_wrReq) r_wr_data <= mem_wrdin;
            for (int i = 0; i < REGISTER_N; i++)
                r_wr_strb[i] <= (mem_wrReq && !w_wr_err && w_wr_sel[i]) ? mem_wrByteStrobe : '0;
        end
    end

    // Data only moves on a request so mem_rddout holds between valid pulses.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rd_vld  <= 1'b0;
            r_rd_err  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= mem_rdReq;
            r_rd_err <= mem_rdReq & w_rd_err;
            if (mem_rdReq) r_rd_data <= w_rd_mux;
        end
    end

`ifdef MEM_REGS_PIPE_RD_PIPE_EN
    logic                      r_rd_vld2, r_rd_err2;
    logic [REG_DATA_WIDTH-1:0] r_rd_data2;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rd_vld2  <= 1'b0;
            r_rd_err2  <= 1'b0;
            r_rd_data2 <= '0;
        end else begin
            r_rd_vld2 <= r_rd_vld;
            r_rd_err2 <= r_rd_err;
            if (r_rd_vld) r_rd_data2 <= r_rd_data;
        end
    end

    assign mem_rdValid = r_rd_vld2;
    assign mem_rdErr   = r_rd_err2;
    assign mem_rddout  = r_rd_data2;
`else
    assign mem_rdValid = r_rd_vld;
    assign mem_rdErr   = r_rd_err;
    assign mem_rddout  = r_rd_data;
`endif

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn)  r_err_cnt <= '0;
        else if (err_clr) r_err_cnt <= '0;
        else              r_err_cnt <= err_sat_add(r_err_cnt, w_err_inc);
    end

    assign mem_wrAck        = r_wr_ack;
    assign mem_wrErr        = r_wr_err;
    assign reg_wrdout       = r_wr_data;
    assign reg_wrByteStrobe = r_wr_strb;
    assign reg_rdStrobe     = (mem_rdReq && axi_resetn) ? w_rd_sel : '0;
    assign err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_mem_regs_pipe.sv
// Randomized bench for mem_regs_pipe against a transaction-level model (queue of pending reads,
// integer error count). Honours MEM_REGS_PIPE_RD_PIPE_EN for the read latency.
module tb_mem_regs_pipe;

`ifdef MEM_REGS_PIPE_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [15:0] RO = 16'h0002;

    logic              axi_clk, axi_resetn;
    logic              mem_wrReq, mem_rdReq, err_clr;
    logic [8:0]        mem_wrAddr, mem_rdAddr;
    logic [31:0]       mem_wrdin, mem_rddout, reg_wrdout;
    logic [3:0]        mem_wrByteStrobe;
    logic              mem_wrAck, mem_wrErr, mem_rdValid, mem_rdErr;
    logic [15:0][3:0]  reg_wrByteStrobe;
    logic [15:0]       reg_rdStrobe;
    logic [15:0][31:0] reg_rddin;
    logic [15:0]       err_cnt;

    mem_regs_pipe #(.REGISTER_N(16), .REG_DATA_WIDTH(32), .REG_ADDR_WIDTH(9), .RO_MASK(RO)) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .mem_wrReq(mem_wrReq), .mem_wrAddr(mem_wrAddr), .mem_wrdin(mem_wrdin),
        .mem_wrByteStrobe(mem_wrByteStrobe), .mem_wrAck(mem_wrAck), .mem_wrErr(mem_wrErr),
        .mem_rdReq(mem_rdReq), .mem_rdAddr(mem_rdAddr), .mem_rddout(mem_rddout),
        .mem_rdValid(mem_rdValid), .mem_rdErr(mem_rdErr),
        .reg_wrdout(reg_wrdout), .reg_wrByteStrobe(reg_wrByteStrobe),
        .reg_rdStrobe(reg_rdStrobe), .reg_rddin(reg_rddin),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    typedef struct { int due; logic err; logic [31:0] data; } rd_t;
    rd_t rq[$];

    int               n_chk = 0, n_pass = 0, cyc = 0, cnt = 0;
    logic             e_ack = 0, e_werr = 0;
    logic [15:0][3:0] e_strb = '0;
    logic [31:0]      e_wdat = '0, last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic idle();
        mem_wrReq = 0; mem_rdReq = 0; err_clr = 0;
        mem_wrAddr = '0; mem_rdAddr = '0; mem_wrdin = '0; mem_wrByteStrobe = '0;
    endtask

    task automatic rand_rddin();
        for (int i = 0; i < 16; i++) reg_rddin[i] = $urandom;
    endtask

    task automatic chk_reset_zero();
        chk("rst_wrAck", 64'(mem_wrAck), 64'(0));
        chk("rst_wrErr", 64'(mem_wrErr), 64'(0));
        chk("rst_rdValid", 64'(mem_rdValid), 64'(0));
        chk("rst_rdErr", 64'(mem_rdErr), 64'(0));
        chk("rst_rddout", 64'(mem_rddout), 64'(0));
        chk("rst_wrdout", 64'(reg_wrdout), 64'(0));
        chk("rst_wrstb", 64'(reg_wrByteStrobe), 64'(0));
        chk("rst_rdstb", 64'(reg_rdStrobe), 64'(0));
        chk("rst_errcnt", 64'(err_cnt), 64'(0));
    endtask

    // One clock: check the combinational read strobe, advance the model, then check outputs.
    task automatic cycle();
        logic [15:0] e_rs;
        logic        wlegal, rbad;
        int          errs;
        rd_t         r;
        #1;
        rbad = (mem_rdAddr >= 16);
        e_rs = '0;
        if (mem_rdReq && !rbad) e_rs[mem_rdAddr[3:0]] = 1'b1;
        chk("rdStrobe", 64'(reg_rdStrobe), 64'(e_rs));

        wlegal = (mem_wrAddr < 16) && !((RO >> mem_wrAddr[3:0]) & 16'h1);
        e_ack  = mem_wrReq;
        e_werr = mem_wrReq && !wlegal;
        e_strb = '0;
        if (mem_wrReq && wlegal) e_strb[mem_wrAddr[3:0]] = mem_wrByteStrobe;
        if (mem_wrReq) e_wdat = mem_wrdin;
        if (mem_rdReq) begin
            r.due  = cyc + LAT;
            r.err  = rbad;
            r.data = rbad ? 32'h0 : reg_rddin[mem_rdAddr[3:0]];
            rq.push_back(r);
        end
        errs = int'(e_werr) + int'(mem_rdReq && rbad);
        if (err_clr) cnt = 0;
        else cnt = (cnt + errs > 65535) ? 65535 : cnt + errs;

        @(posedge axi_clk); #1;
        cyc++;
        chk("wrAck", 64'(mem_wrAck), 64'(e_ack));
        chk("wrErr", 64'(mem_wrErr), 64'(e_werr));
        chk("wrStrobe", 64'(reg_wrByteStrobe), 64'(e_strb));
        if (e_ack && !e_werr) chk("wrdout", 64'(reg_wrdout), 64'(e_wdat));
        chk("err_cnt", 64'(err_cnt), 64'(cnt));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rdValid", 64'(mem_rdValid), 64'(1));
            chk("rdErr", 64'(mem_rdErr), 64'(rq[0].err));
            chk("rddout", 64'(mem_rddout), 64'(rq[0].data));
            last_rd = rq[0].data;
            void'(rq.pop_front());
        end else begin
            chk("rdValid_idle", 64'(mem_rdValid), 64'(0));
            chk("rdErr_idle", 64'(mem_rdErr), 64'(0));
            chk("rddout_hold", 64'(mem_rddout), 64'(last_rd));
        end
    endtask

    initial begin
        axi_resetn = 0;
        idle();
        rand_rddin();
        #2 chk_reset_zero();
        repeat (2) @(posedge axi_clk);
        #3 axi_resetn = 1;

        // write addr 3, then RO write to addr 1
        mem_wrReq = 1; mem_wrAddr = 3; mem_wrdin = 32'hDEADBEEF; mem_wrByteStrobe = 4'b0101;
        cycle();
        mem_wrAddr = 1; mem_wrdin = 32'h12345678; mem_wrByteStrobe = 4'hF;
        cycle();
        idle();
        // out-of-range read
        mem_rdReq = 1; mem_rdAddr = 20;
        cycle();
        // back-to-back reads 0,1,2
        for (int i = 0; i < 16; i++) reg_rddin[i] = 32'(i + 1);
        for (int a = 0; a < 3; a++) begin
            mem_rdReq = 1; mem_rdAddr = 9'(a);
            cycle();
        end
        idle();
        repeat (3) cycle();

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            rand_rddin();
            mem_wrReq = 1'($urandom_range(0, 1));
            mem_wrAddr = 9'($urandom_range(0, 20));
            mem_wrdin = $urandom;
            mem_wrByteStrobe = 4'($urandom);
            mem_rdReq = 1'($urandom_range(0, 1));
            mem_rdAddr = 9'($urandom_range(0, 20));
            err_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end

        // drive err_cnt to 16'hFFFE with double errors, then saturate and clear
        idle();
        err_clr = 1;
        cycle();
        err_clr = 0;
        mem_wrReq = 1; mem_wrAddr = 1; mem_rdReq = 1; mem_rdAddr = 20;
        for (int k = 0; k < 32767; k++) cycle();
        chk("cnt_fffe", 64'(err_cnt), 64'(16'hFFFE));
        cycle();
        chk("cnt_sat", 64'(err_cnt), 64'(16'hFFFF));
        cycle();
        err_clr = 1;
        cycle();
        chk("cnt_clr", 64'(err_cnt), 64'(0));
        idle();
        repeat (3) cycle();

        // reset one cycle after a read request
        rand_rddin();
        mem_rdReq = 1; mem_rdAddr = 5;
        cycle();
        mem_wrReq = 1; mem_wrAddr = 2; mem_wrByteStrobe = 4'hF;
        #1 axi_resetn = 0;
        #1 chk_reset_zero();
        rq.delete(); cnt = 0; last_rd = '0;
        @(posedge axi_clk); #1;
        chk_reset_zero();
        idle();
        #1 axi_resetn = 1;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
